key_sequencer: RTL and testbench

KEY_SEQUENCER -- requirements
Module: key_sequencer

---
 rtl/key_sequencer.sv | 156 +++++++++++++++
 tb/tb_key_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : key_sequencer
// Brief    : Drives a packed code onto a 2-bit symbol bus and reports whether
//            the downstream lock opened. Optional macro KEY_SEQUENCER_RETRY_EN
//            enables up to three attempts before reporting failure.
// Revision : 1.0 - initial release
// ============================================================================
module key_sequencer #(
    parameter int          LEN  = 4,
    parameter int          HOLD = 2,
    parameter logic [15:0] CODE = 16'h00E7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       unlocked,
    output logic [1:0] s,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    localparam logic [2:0] c_last_idx  = 3'(LEN - 1);
    localparam logic [3:0] c_last_hold = 4'(HOLD - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        GAP   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic [3:0] r_hold, w_hold_nxt;
    logic [1:0] r_s, w_s_nxt;
    logic       r_busy, r_done, r_fail;
    logic       w_done_nxt, w_fail_nxt;
`ifdef KEY_SEQUENCER_RETRY_EN
    logic [1:0] r_attempt, w_attempt_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        w_done_nxt  = 1'b0;
        w_fail_nxt  = 1'b0;
`ifdef KEY_SEQUENCER_RETRY_EN
        w_attempt_nxt = r_attempt;
`endif
        case (r_state)
            IDLE: begin
                w_idx_nxt  = 3'd0;
                w_hold_nxt = 4'd0;
`ifdef KEY_SEQUENCER_RETRY_EN
                w_attempt_nxt = 2'd0;
`endif
                if (start && !abort) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (r_hold == c_last_hold) begin
                    w_hold_nxt  = 4'd0;
                    w_state_nxt = GAP;
                end else begin
                    w_hold_nxt = r_hold + 4'd1;
                end
            end
            GAP: begin
                if (r_idx == c_last_idx) begin
                    w_state_nxt = CHECK;
                end else begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_state_nxt = SEND;
                end
            end
            CHECK: begin
                if (unlocked) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
`ifdef KEY_SEQUENCER_RETRY_EN
                    // Two silent retries; the third failure is reported.
                    if (r_attempt < 2'd2) begin
                        w_attempt_nxt = r_attempt + 2'd1;
                        w_idx_nxt     = 3'd0;
                        w_hold_nxt    = 4'd0;
                        w_state_nxt   = SEND;
                    end else begin
                        w_state_nxt = DONE;
                        w_fail_nxt  = 1'b1;
                    end
`else
                    w_state_nxt = DONE;
                    w_fail_nxt  = 1'b1;
`endif
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        if (abort && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = 3'd0;
            w_hold_nxt  = 4'd0;
            w_done_nxt  = 1'b0;
            w_fail_nxt  = 1'b0;
        end

        // Outputs are computed from the next state so they register cleanly.
        w_s_nxt = (w_state_nxt == SEND) ? CODE[{w_idx_nxt, 1'b0} +: 2] : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_hold  <= 4'd0;
            r_s     <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_hold  <= w_hold_nxt;
            r_s     <= w_s_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

`ifdef KEY_SEQUENCER_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_attempt <= 2'd0;
        end else begin
            r_attempt <= w_attempt_nxt;
        end
    end
`endif

    assign s    = r_s;
    assign busy = r_busy;
    assign done = r_done;
    assign fail = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_sequencer
// Brief    : Directed self-checking bench for key_sequencer (default config and
//            LEN=1/HOLD=1 config); honours KEY_SEQUENCER_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, unlocked;
    logic [1:0] s;
    logic       busy, done, fail;
    logic       start_b, abort_b, unlocked_b;
    logic [1:0] s_b;
    logic       busy_b, done_b, fail_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] c_sym_tbl [13] = '{2'd3, 2'd3, 2'd0, 2'd1, 2'd1, 2'd0,
                                  2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0};

    key_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .unlocked(unlocked),
        .s(s), .busy(busy), .done(done), .fail(fail)
    );

    key_sequencer #(.LEN(1), .HOLD(1), .CODE(16'h0001)) u_dut_small (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .unlocked(unlocked_b),
        .s(s_b), .busy(busy_b), .done(done_b), .fail(fail_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge (cycle 0); start stays high for start_len cycles.
    task automatic run_seq(input int n_att, input bit exp_pass, input int start_len);
        int total;
        int exp_s;
        total = 13 * n_att + 1;
        start = 1'b1;
        for (int c = 1; c <= total + 2; c++) begin
            @(negedge clk);
            start = (c < start_len);
            exp_s = (c <= 13 * n_att) ? int'(c_sym_tbl[(c - 1) % 13]) : 0;
            check_eq($sformatf("s@%0d", c), int'(s), exp_s);
            check_eq($sformatf("busy@%0d", c), int'(busy), int'(c <= total));
            check_eq($sformatf("done@%0d", c), int'(done), int'(c == total && exp_pass));
            check_eq($sformatf("fail@%0d", c), int'(fail), int'(c == total && !exp_pass));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; unlocked = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; unlocked_b = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_s", int'(s), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_fail", int'(fail), 0);
        rst = 1'b0;
        @(negedge clk);

        // Lock opens: done pulse after 14 cycles.
        run_seq(1, 1'b1, 1);

        // Lock stays shut.
        unlocked = 1'b0;
`ifdef KEY_SEQUENCER_RETRY_EN
        run_seq(3, 1'b0, 1);
`else
        run_seq(1, 1'b0, 1);
`endif
        unlocked = 1'b1;

        // start held while busy must not queue a second sequence.
        run_seq(1, 1'b1, 11);

        // start and abort together in IDLE stay idle.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", int'(busy), 0);
        check_eq("start_abort_s", int'(s), 0);

        // Abort at cycle 5, restart at cycle 8.
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("abort_pre_s", int'(s), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_s", int'(s), 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_fail", int'(fail), 0);
        @(negedge clk);
        check_eq("abort_idle_busy", int'(busy), 0);
        check_eq("abort_idle_pulse", int'(done | fail), 0);
        @(negedge clk);
        run_seq(1, 1'b1, 1);

        // Asynchronous reset mid-SEND at cycle 7.
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("rstmid_pre_s", int'(s), 2);
        rst = 1'b1;
        #1;
        check_eq("rstmid_s", int'(s), 0);
        check_eq("rstmid_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("rstmid_pulse%0d", c), int'(done | fail), 0);
            check_eq($sformatf("rstmid_idle%0d", c), int'(busy), 0);
        end
        run_seq(1, 1'b1, 1);

        // LEN=1, HOLD=1 instance: s=1,0,0 then done at cycle 4.
        start_b = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            check_eq($sformatf("small_s@%0d", c), int'(s_b), int'(c == 1));
            check_eq($sformatf("small_busy@%0d", c), int'(busy_b), int'(c <= 4));
            check_eq($sformatf("small_done@%0d", c), int'(done_b), int'(c == 4));
            check_eq($sformatf("small_fail@%0d", c), int'(fail_b), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
